// File: rtl/padding_read_ctrl_l10_pkg.sv
// Shared definitions for the layer-10 padded feature-map read controller:
// per-layer geometry, scan FSM states and the tag carried alongside BRAM reads.
package padding_read_ctrl_l10_pkg;

    localparam int L10_IMG_W    = 14;
    localparam int L10_IMG_H    = 14;
    localparam int L10_PAD      = 1;
    localparam int L10_ADDR_W   = 8;
    localparam int L10_BRAM_LAT = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic valid;
        logic pad;
        logic last;
    } pad_tag_t;

    // Bits needed to count 0..n-1 (at least one bit).
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/padding_tag_delay.sv
// LAT-deep shift register for the {valid, pad, last} beat tag; freezes while
// the enable is low so the tag stays aligned with a stalled BRAM output.
module padding_tag_delay
    import padding_read_ctrl_l10_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     i_en,
    input  pad_tag_t i_tag,
    output pad_tag_t o_tag
);

    pad_tag_t r_pipe [LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                r_pipe[i] <= '0;
            end
        end else if (i_en) begin
            r_pipe[0] <= i_tag;
            for (int i = 1; i < LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_tag = r_pipe[LAT-1];

endmodule

// File: rtl/padding_read_ctrl_l10.sv
// Raster scan of the zero-padded frame: interior positions issue BRAM reads,
// border positions raise pad_sel, with the tag delayed to match read latency.
module padding_read_ctrl_l10
    import padding_read_ctrl_l10_pkg::*;
#(
    parameter int IMG_W    = L10_IMG_W,
    parameter int IMG_H    = L10_IMG_H,
    parameter int PAD      = L10_PAD,
    parameter int ADDR_W   = L10_ADDR_W,
    parameter int BRAM_LAT = L10_BRAM_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              hold,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              bram_en,
    output logic              pad_sel,
    output logic              out_valid,
    output logic              frame_done,
    output logic              busy
);

    localparam int PW = IMG_W + 2 * PAD;
    localparam int PH = IMG_H + 2 * PAD;
    localparam int CW = cnt_w(PW);
    localparam int RW = cnt_w(PH);
    localparam int DW = cnt_w(BRAM_LAT);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [RW-1:0]     r_row;
    logic [CW-1:0]     r_col;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W-1:0] r_addr_hold;
    logic [DW-1:0]     r_drain_cnt;

    logic              w_issue;
    logic              w_border;
    logic              w_rd;
    logic              w_col_end;
    logic              w_last_pos;
    pad_tag_t          w_tag_in;
    pad_tag_t          w_tag_out;

    // Signed compares keep PAD=0 legal without constant-false unsigned tests.
    function automatic logic row_is_border(input logic [RW-1:0] r);
        int ri;
        ri = int'(r);
        return (ri < PAD) || (ri >= IMG_H + PAD);
    endfunction

    function automatic logic col_is_border(input logic [CW-1:0] c);
        int ci;
        ci = int'(c);
        return (ci < PAD) || (ci >= IMG_W + PAD);
    endfunction

    assign w_issue    = (r_state == RUN) && !hold;
    assign w_border   = row_is_border(r_row) || col_is_border(r_col);
    assign w_rd       = w_issue && !w_border;
    assign w_col_end  = (r_col == CW'(PW - 1));
    assign w_last_pos = w_col_end && (r_row == RW'(PH - 1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_issue && w_last_pos) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!hold && (r_drain_cnt == DW'(BRAM_LAT - 1))) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Issue stage: position counters and the running read pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row       <= '0;
            r_col       <= '0;
            r_rd_ptr    <= '0;
            r_addr_hold <= '0;
        end else if ((r_state == IDLE) && start) begin
            r_row    <= '0;
            r_col    <= '0;
            r_rd_ptr <= '0;
        end else if (w_issue) begin
            if (w_col_end) begin
                r_col <= '0;
                r_row <= w_last_pos ? '0 : r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
            if (w_rd) begin
                r_rd_ptr    <= r_rd_ptr + ADDR_W'(1);
                r_addr_hold <= r_rd_ptr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drain_cnt <= '0;
        end else if (r_state != DRAIN) begin
            r_drain_cnt <= '0;
        end else if (!hold) begin
            r_drain_cnt <= r_drain_cnt + DW'(1);
        end
    end

    always_comb begin
        w_tag_in = '0;
        if (w_issue) begin
            w_tag_in.valid = 1'b1;
            w_tag_in.pad   = w_border;
            w_tag_in.last  = w_last_pos;
        end
    end

    // Tag pipe: matches the BRAM read latency and stalls with hold.
    padding_tag_delay #(
        .LAT (BRAM_LAT)
    ) u_tag_delay (
        .clk   (clk),
        .rst   (rst),
        .i_en  (!hold),
        .i_tag (w_tag_in),
        .o_tag (w_tag_out)
    );

    // Output stage: mux select and beat qualifiers.
    assign bram_en    = w_rd;
    assign bram_addr  = w_rd ? r_rd_ptr : r_addr_hold;
    assign pad_sel    = w_tag_out.pad;
    assign out_valid  = w_tag_out.valid && !hold;
    assign frame_done = out_valid && w_tag_out.last;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_padding_read_ctrl_l10.sv
// Bench for padding_read_ctrl_l10: three geometries, each with a BRAM model,
// a padded-frame reference queue and a monitor comparing the muxed stream.
module tb_padding_read_ctrl_l10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    function automatic int cfg_w(input int g);
        return (g == 1) ? 14 : 4;
    endfunction
    function automatic int cfg_p(input int g);
        return (g == 2) ? 0 : 1;
    endfunction
    function automatic int cfg_l(input int g);
        return (g == 1) ? 2 : 1;
    endfunction

    // Content of BRAM word a (one lane); never zero so padding is distinguishable.
    function automatic logic [15:0] word_of(input int a);
        return 16'hC000 | 16'(a);
    endfunction

    typedef struct packed {
        logic [15:0] data;
        logic        pad;
        logic        last;
    } beat_t;

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int W  = cfg_w(g);
        localparam int H  = cfg_w(g);
        localparam int P  = cfg_p(g);
        localparam int L  = cfg_l(g);
        localparam int PW = W + 2 * P;
        localparam int PH = H + 2 * P;
        localparam int NB = PW * PH;

        logic        rst, start, hold;
        logic [7:0]  bram_addr;
        logic        bram_en, pad_sel, out_valid, frame_done, busy;
        logic [15:0] d1, dout, mux;
        beat_t       q[$];
        beat_t       exp_b;
        int          beats = 0;
        int          interior = 0;
        bit          prev_fd = 1'b0;
        bit          fin = 1'b0;

        padding_read_ctrl_l10 #(
            .IMG_W    (W),
            .IMG_H    (H),
            .PAD      (P),
            .ADDR_W   (8),
            .BRAM_LAT (L)
        ) dut (
            .clk        (clk),
            .rst        (rst),
            .start      (start),
            .hold       (hold),
            .bram_addr  (bram_addr),
            .bram_en    (bram_en),
            .pad_sel    (pad_sel),
            .out_valid  (out_valid),
            .frame_done (frame_done),
            .busy       (busy)
        );

        // BRAM: read register loads on enable; optional output register stalls on hold.
        always @(posedge clk) begin
            if (L == 1) begin
                if (bram_en) dout <= word_of(int'(bram_addr));
            end else begin
                if (bram_en) d1 <= word_of(int'(bram_addr));
                if (!hold) dout <= d1;
            end
        end
        assign mux = pad_sel ? 16'h0000 : dout;

        function automatic string nm(input string s);
            return $sformatf("c%0d_%s", g, s);
        endfunction

        task automatic tick();
            @(posedge clk);
            #1;
        endtask

        task automatic push_frame();
            beat_t b;
            for (int r = 0; r < PH; r++) begin
                for (int c = 0; c < PW; c++) begin
                    b.pad  = (r < P) || (r >= H + P) || (c < P) || (c >= W + P);
                    b.data = b.pad ? 16'h0000 : word_of((r - P) * W + (c - P));
                    b.last = (r == PH - 1) && (c == PW - 1);
                    q.push_back(b);
                end
            end
        endtask

        task automatic wait_empty(input string tag);
            for (int k = 0; k < NB * 4 + 100 && q.size() != 0; k++) tick();
            chk(nm({tag, "_drained"}), q.size(), 0);
            hold  = 1'b0;
            start = 1'b0;
        endtask

        always @(negedge clk) begin
            if (prev_fd) chk(nm("busy_after_done"), busy, 1'b0);
            prev_fd = (frame_done === 1'b1);
            if (out_valid === 1'b1) begin
                if (q.size() == 0) begin
                    chk(nm("unexpected_beat"), out_valid, 1'b0);
                end else begin
                    exp_b = q.pop_front();
                    chk(nm("mux_data"), mux, exp_b.data);
                    chk(nm("pad_sel"), pad_sel, exp_b.pad);
                    chk(nm("frame_done"), frame_done, exp_b.last);
                    beats++;
                    if (pad_sel === 1'b0) interior++;
                    if (exp_b.last) begin
                        chk(nm("beats_per_frame"), beats, NB);
                        chk(nm("interior_beats"), interior, W * H);
                        beats    = 0;
                        interior = 0;
                    end
                end
            end else if (frame_done === 1'b1) begin
                chk(nm("done_without_valid"), frame_done, 1'b0);
            end
            if (rst) begin
                beats    = 0;
                interior = 0;
            end
        end

        initial begin
            int k;
            int n;
            rst   = 1'b1;
            start = 1'b0;
            hold  = 1'b0;
            repeat (3) tick();
            chk(nm("reset_outputs"), {bram_addr, bram_en, pad_sel, out_valid, frame_done, busy}, '0);
            rst = 1'b0;
            hold = 1'b1;
            tick();
            chk(nm("hold_idle_busy"), busy, 1'b0);
            hold = 1'b0;
            tick();

            // Clean frame: latency, first beat, start in final drain cycle.
            push_frame();
            start = 1'b1;
            tick();
            start = 1'b0;
            chk(nm("busy_after_start"), busy, 1'b1);
            k = 1;
            while (out_valid !== 1'b1 && k < 20) begin
                tick();
                k++;
            end
            chk(nm("first_beat_latency"), k, 1 + L);
            chk(nm("first_beat_pad"), pad_sel, (P > 0) ? 1'b1 : 1'b0);
            repeat (NB - 1) tick();
            chk(nm("done_on_last_beat"), frame_done, 1'b1);
            start = 1'b1;
            tick();
            start = 1'b0;
            chk(nm("busy_fall"), busy, 1'b0);
            repeat (L + 3) tick();
            chk(nm("late_start_ignored"), busy, 1'b0);
            chk(nm("frame_a_queue"), q.size(), 0);

            // Three-cycle hold beginning at the issue of position (2,0).
            push_frame();
            start = 1'b1;
            tick();
            start = 1'b0;
            repeat (2 * PW) tick();
            for (int i = 0; i < 3; i++) begin
                hold = 1'b1;
                #1;
                chk(nm("hold_no_valid"), out_valid, 1'b0);
                chk(nm("hold_no_read"), bram_en, 1'b0);
                tick();
            end
            hold = 1'b0;
            wait_empty("hold_frame");

            // Reset on beat 10, then a full frame from address 0.
            push_frame();
            start = 1'b1;
            tick();
            start = 1'b0;
            n = 0;
            k = 0;
            while (k < 200) begin
                if (out_valid === 1'b1) n++;
                if (n == 10) break;
                tick();
                k++;
            end
            chk(nm("reached_beat10"), n, 10);
            rst = 1'b1;
            tick();
            chk(nm("abort_outputs"), {bram_addr, bram_en, pad_sel, out_valid, frame_done, busy}, '0);
            q.delete();
            rst = 1'b0;
            repeat (4) tick();
            chk(nm("idle_after_abort"), {out_valid, frame_done, busy}, '0);
            push_frame();
            start = 1'b1;
            tick();
            start = 1'b0;
            wait_empty("post_reset_frame");

            // Random frames with random holds and ignored mid-frame starts.
            for (int f = 0; f < 4; f++) begin
                repeat ($urandom_range(0, 3)) tick();
                push_frame();
                start = 1'b1;
                hold  = $urandom_range(0, 1) == 1;
                tick();
                start = 1'b0;
                for (int c = 0; c < NB * 4 + 100 && q.size() != 0; c++) begin
                    hold  = ($urandom_range(0, 3) == 0);
                    start = ($urandom_range(0, 7) == 0);
                    tick();
                end
                wait_empty("random_frame");
                tick();
                chk(nm("random_idle"), busy, 1'b0);
            end
            fin = 1'b1;
        end
    end

    initial begin
        for (int k = 0; k < 60000; k++) begin
            @(posedge clk);
            if (g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin) break;
        end
        chk("all_configs_finished", {g_cfg[0].fin, g_cfg[1].fin, g_cfg[2].fin}, 3'b111);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
